// File: rtl/dds_sine_shaper_if.sv
// dds_sine_shaper_if
//   Groups the phase input, gain control and sample output of dds_sine_shaper
//   into one bundle.
//   Parameters: OUT_W  - signed sample width
//               GAIN_W - unsigned gain width (256 = unity)
//   Modports:
//     master - accumulator/control side: drives phase_in, phase_valid,
//              gain_in, gain_load; observes sample_out, sample_valid,
//              gain_active, gain_busy
//     slave  - the shaper itself: the reverse directions
interface dds_sine_shaper_if #(
  parameter int OUT_W  = 16,
  parameter int GAIN_W = 9
);
  logic [9:0]        phase_in;
  logic              phase_valid;
  logic [GAIN_W-1:0] gain_in;
  logic              gain_load;
  logic [OUT_W-1:0]  sample_out;
  logic              sample_valid;
  logic [GAIN_W-1:0] gain_active;
  logic              gain_busy;

  modport master (
    output phase_in, phase_valid, gain_in, gain_load,
    input  sample_out, sample_valid, gain_active, gain_busy
  );

  modport slave (
    input  phase_in, phase_valid, gain_in, gain_load,
    output sample_out, sample_valid, gain_active, gain_busy
  );
endinterface

// File: rtl/dds_sine_shaper.sv
// dds_sine_shaper
//   Turns 10-bit DDS phase words into signed sine samples via a registered
//   quarter-wave ROM, then scales them by a per-band gain. New gains are only
//   applied at waveform zero crossings so band-level changes do not click.
//   Three-stage pipeline: S1 phase register, S2 ROM read with sign/mirror,
//   S3 multiply and arithmetic shift. One sample per clock.
//   Ports:
//     clock - system clock
//     reset - asynchronous, active-high
//     bus   - dds_sine_shaper_if.slave (phase_in/phase_valid, gain_in/
//             gain_load, sample_out/sample_valid, gain_active/gain_busy)
//   Optional feature macro: GAIN_RAMP_EN
//     defined   - after the first crossing, gain_active walks 1 LSB per valid
//                 sample toward the target
//     undefined - gain_active jumps to the target at the crossing
module dds_sine_shaper #(
  parameter int OUT_W      = 16,
  parameter int GAIN_W     = 9,
  parameter int GAIN_RESET = 256
) (
  input  logic             clock,
  input  logic             reset,
  dds_sine_shaper_if.slave bus
);

  localparam int ROM_W    = OUT_W - 1;
  localparam int PROD_W   = OUT_W + GAIN_W;
  localparam int UNITY_SH = 8;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = GAIN_W'(1 << UNITY_SH);
  localparam logic [GAIN_W-1:0] GAIN_INIT  = GAIN_W'(GAIN_RESET);

  typedef enum logic [1:0] {
    GAIN_IDLE,
    GAIN_PENDING,
    GAIN_RAMP
  } gain_state_t;

  // Quarter-wave table sampled at half-LSB phase offsets, so the mirrored
  // quadrants reuse it exactly and no entry is ever zero.
  function automatic logic [ROM_W-1:0] lut_entry(input int k);
    real amp;
    real ang;
    amp = real'((1 << ROM_W) - 1);
    ang = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / 1024.0;
    return ROM_W'($rtoi(amp * $sin(ang) + 0.5));
  endfunction

`ifdef GAIN_RAMP_EN
  function automatic logic [GAIN_W-1:0] step_toward(input logic [GAIN_W-1:0] cur,
                                                    input logic [GAIN_W-1:0] tgt);
    if (cur < tgt) return cur + GAIN_W'(1);
    if (cur > tgt) return cur - GAIN_W'(1);
    return cur;
  endfunction
`endif

  logic [ROM_W-1:0] rom [256];

  for (genvar k = 0; k < 256; k++) begin : g_rom
    localparam logic [ROM_W-1:0] ENTRY = lut_entry(k);
    assign rom[k] = ENTRY;
  end

  logic [9:0]              s1_phase_q, s1_phase_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [1:0]              prev_quad_q, prev_quad_d;
  gain_state_t             gain_state_q, gain_state_d;
  logic [GAIN_W-1:0]       target_q, target_d;
  logic [GAIN_W-1:0]       gain_active_q, gain_active_d;
  logic                    s2_valid_q, s2_valid_d;
  logic signed [OUT_W-1:0] s2_sine_q, s2_sine_d;
  logic [GAIN_W-1:0]       s2_gain_q, s2_gain_d;
  logic                    sample_valid_q, sample_valid_d;
  logic [OUT_W-1:0]        sample_out_q, sample_out_d;

  logic [1:0]               s1_quad;
  logic                     crossing;
  logic [GAIN_W-1:0]        gain_clamped;
  logic [7:0]               rom_index;
  logic [ROM_W-1:0]         rom_mag;
  logic signed [PROD_W-1:0] product;

  assign s1_quad      = s1_phase_q[9:8];
  assign gain_clamped = (bus.gain_in > GAIN_UNITY) ? GAIN_UNITY : bus.gain_in;

  // Zero crossings are rising (q3 -> q0) and falling (q1 -> q2) transitions
  // between valid phase words; bubbles do not disturb the quadrant history.
  assign crossing = s1_valid_q &&
                    (((s1_quad == 2'd0) && (prev_quad_q == 2'd3)) ||
                     ((s1_quad == 2'd2) && (prev_quad_q == 2'd1)));

  // Gain control. The crossing is resolved against the target held before
  // this cycle, so a simultaneous gain_load only becomes the next pending
  // target and keeps the block busy.
  always_comb begin
    gain_state_d  = gain_state_q;
    target_d      = target_q;
    gain_active_d = gain_active_q;
    prev_quad_d   = prev_quad_q;

    if (s1_valid_q) prev_quad_d = s1_quad;

    case (gain_state_q)
      GAIN_PENDING: begin
        if (crossing) begin
`ifdef GAIN_RAMP_EN
          gain_active_d = step_toward(gain_active_q, target_q);
          gain_state_d  = (gain_active_d == target_q) ? GAIN_IDLE : GAIN_RAMP;
`else
          gain_active_d = target_q;
          gain_state_d  = GAIN_IDLE;
`endif
        end
      end
`ifdef GAIN_RAMP_EN
      GAIN_RAMP: begin
        if (s1_valid_q) begin
          gain_active_d = step_toward(gain_active_q, target_q);
          if (gain_active_d == target_q) gain_state_d = GAIN_IDLE;
        end
      end
`endif
      default: ;
    endcase

    if (bus.gain_load) begin
      target_d = gain_clamped;
      if (gain_state_d == GAIN_IDLE) gain_state_d = GAIN_PENDING;
    end
  end

  // Datapath. The S2 gain is the one decided for this very phase word, so a
  // crossing sample already carries the new gain. 255-p is the bitwise
  // complement of p for the mirrored quadrants.
  always_comb begin
    s1_phase_d = bus.phase_in;
    s1_valid_d = bus.phase_valid;

    rom_index  = s1_quad[0] ? ~s1_phase_q[7:0] : s1_phase_q[7:0];
    rom_mag    = rom[rom_index];
    s2_valid_d = s1_valid_q;
    s2_sine_d  = $signed({1'b0, rom_mag});
    if (s1_quad[1]) s2_sine_d = -s2_sine_d;
    s2_gain_d  = gain_active_d;

    product        = PROD_W'(s2_sine_q) * $signed(PROD_W'(s2_gain_q));
    sample_valid_d = s2_valid_q;
    sample_out_d   = sample_out_q;
    if (s2_valid_q) sample_out_d = OUT_W'(product >>> UNITY_SH);
  end

  // All state, including the pipeline valids, is cleared asynchronously so a
  // reset flushes samples in flight and drops any pending gain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_phase_q     <= '0;
      s1_valid_q     <= 1'b0;
      prev_quad_q    <= 2'd0;
      gain_state_q   <= GAIN_IDLE;
      target_q       <= GAIN_INIT;
      gain_active_q  <= GAIN_INIT;
      s2_valid_q     <= 1'b0;
      s2_sine_q      <= '0;
      s2_gain_q      <= GAIN_INIT;
      sample_valid_q <= 1'b0;
      sample_out_q   <= '0;
    end else begin
      s1_phase_q     <= s1_phase_d;
      s1_valid_q     <= s1_valid_d;
      prev_quad_q    <= prev_quad_d;
      gain_state_q   <= gain_state_d;
      target_q       <= target_d;
      gain_active_q  <= gain_active_d;
      s2_valid_q     <= s2_valid_d;
      s2_sine_q      <= s2_sine_d;
      s2_gain_q      <= s2_gain_d;
      sample_valid_q <= sample_valid_d;
      sample_out_q   <= sample_out_d;
    end
  end

  assign bus.sample_out   = sample_out_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.gain_active  = gain_active_q;
  assign bus.gain_busy    = (gain_state_q != GAIN_IDLE);

endmodule

// File: tb/tb_dds_sine_shaper.sv
// tb_dds_sine_shaper
//   Self-checking bench for dds_sine_shaper (default build, gain jumps at the
//   crossing). A behavioural model computes the full-wave sine from the
//   phase directly, tracks the gain rules as events, and delays each result
//   by the pipeline latency; outputs are compared every cycle. Directed
//   sequences pin the model with hand-computed values, then randomized
//   phase/valid/gain traffic runs against the model.
module tb_dds_sine_shaper;
  localparam int OUT_W  = 16;
  localparam int GAIN_W = 9;

  logic clock = 1'b0;
  logic reset;

  always #500 clock = ~clock;

  dds_sine_shaper_if #(.OUT_W(OUT_W), .GAIN_W(GAIN_W)) bus ();

  dds_sine_shaper #(
    .OUT_W     (OUT_W),
    .GAIN_W    (GAIN_W),
    .GAIN_RESET(256)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_vectors     = 0;
  int n_miscompares = 0;

  // Reference model state
  typedef struct {
    bit valid;
    int value;
  } exp_t;

  int   sine_tab [1024];
  int   m_target, m_active, m_prev_quad, m_last_phase, m_sample;
  bit   m_busy, m_last_valid, m_valid;
  exp_t m_line [$];

  // Full-wave sine, rounded half away from zero, straight from the formula.
  task automatic buildSineTable();
    real r;
    for (int k = 0; k < 1024; k++) begin
      r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / 1024.0);
      sine_tab[k] = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
    end
  endtask

  function automatic int floorDiv256(input int p);
    int q;
    q = p / 256;
    if ((p < 0) && ((p % 256) != 0)) q = q - 1;
    return q;
  endfunction

  task automatic modelReset();
    m_target     = 256;
    m_active     = 256;
    m_busy       = 1'b0;
    m_prev_quad  = 0;
    m_last_valid = 1'b0;
    m_last_phase = 0;
    m_sample     = 0;
    m_valid      = 1'b0;
    m_line.delete();
  endtask

  // One clock of the model. The phase captured on the previous clock has its
  // gain decided now (old target wins over a gain_load in the same clock),
  // and its sample emerges two clocks later.
  task automatic modelStep(input int ph, input bit v, input bit ld, input int g);
    exp_t e;
    exp_t o;
    int   q;
    e.valid = m_last_valid;
    e.value = 0;
    if (m_last_valid) begin
      q = m_last_phase / 256;
      if (m_busy && (((q == 0) && (m_prev_quad == 3)) || ((q == 2) && (m_prev_quad == 1)))) begin
        m_active = m_target;
        m_busy   = 1'b0;
      end
      e.value     = floorDiv256(sine_tab[m_last_phase] * m_active);
      m_prev_quad = q;
    end
    if (ld) begin
      m_target = (g > 256) ? 256 : g;
      m_busy   = 1'b1;
    end
    m_line.push_back(e);
    if (m_line.size() > 1) begin
      o       = m_line.pop_front();
      m_valid = o.valid;
      if (o.valid) m_sample = o.value;
    end
    m_last_valid = v;
    m_last_phase = ph % 1024;
  endtask

  task automatic compare(input string name, input int got, input int want);
    n_vectors++;
    if (got != want) begin
      n_miscompares++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, got, want);
    end
  endtask

  task automatic checkOutput();
    compare("sample_valid", int'(bus.sample_valid), int'(m_valid));
    compare("sample_out", int'($signed(bus.sample_out)), m_sample);
    compare("gain_active", int'(bus.gain_active), m_active);
    compare("gain_busy", int'(bus.gain_busy), int'(m_busy));
  endtask

  // Drive one clock of inputs, advance the model, and check after the edge.
  task automatic applyStimulus(input int ph, input bit v, input bit ld, input int g);
    bus.phase_in    = 10'(ph);
    bus.phase_valid = v;
    bus.gain_load   = ld;
    bus.gain_in     = 9'(g);
    modelStep(ph, v, ld, g);
    @(negedge clock);
    checkOutput();
  endtask

  function automatic int sampleNow();
    return int'($signed(bus.sample_out));
  endfunction

  initial begin
    #50_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ph;
    bit v;
    bit ld;
    int g;

    buildSineTable();
    compare("model_lut0", sine_tab[0], 101);
    compare("model_lut255", sine_tab[255], 32767);

    reset           = 1'b1;
    bus.phase_in    = '0;
    bus.phase_valid = 1'b0;
    bus.gain_in     = '0;
    bus.gain_load   = 1'b0;
    modelReset();
    repeat (2) @(negedge clock);
    compare("reset_sample_valid", int'(bus.sample_valid), 0);
    compare("reset_sample_out", sampleNow(), 0);
    compare("reset_gain_active", int'(bus.gain_active), 256);
    compare("reset_gain_busy", int'(bus.gain_busy), 0);
    reset = 1'b0;

    $display("[TB] quadrant peaks at unity gain");
    applyStimulus(0, 1, 0, 0);
    applyStimulus(256, 1, 0, 0);
    applyStimulus(512, 1, 0, 0);
    compare("q0_valid", int'(bus.sample_valid), 1);
    compare("q0_sample", sampleNow(), 101);
    applyStimulus(768, 1, 0, 0);
    compare("q1_sample", sampleNow(), 32767);
    applyStimulus(0, 0, 0, 0);
    compare("q2_sample", sampleNow(), -101);
    applyStimulus(0, 0, 0, 0);
    compare("q3_sample", sampleNow(), -32767);
    compare("unity_gain_active", int'(bus.gain_active), 256);

    $display("[TB] bubble propagation");
    applyStimulus(256, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(768, 1, 0, 0);
    compare("bubble_v1", int'(bus.sample_valid), 1);
    compare("bubble_s1", sampleNow(), 32767);
    applyStimulus(0, 0, 0, 0);
    compare("bubble_v0", int'(bus.sample_valid), 0);
    compare("bubble_hold", sampleNow(), 32767);
    applyStimulus(0, 0, 0, 0);
    compare("bubble_v2", int'(bus.sample_valid), 1);
    compare("bubble_s2", sampleNow(), -32767);

    $display("[TB] half gain at a falling crossing");
    applyStimulus(300, 1, 1, 128);
    compare("g128_busy", int'(bus.gain_busy), 1);
    applyStimulus(520, 1, 0, 0);
    applyStimulus(256, 1, 0, 0);
    compare("g128_active", int'(bus.gain_active), 128);
    compare("g128_idle", int'(bus.gain_busy), 0);
    applyStimulus(768, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    compare("g128_peak", sampleNow(), 16383);
    applyStimulus(0, 0, 0, 0);
    compare("g128_trough", sampleNow(), -16384);

    $display("[TB] clamped gain waits for q1 -> q2");
    applyStimulus(50, 1, 0, 0);
    ph = 100;
    applyStimulus(ph, 1, 1, 400);
    compare("clamp_busy", int'(bus.gain_busy), 1);
    compare("clamp_hold_gain", int'(bus.gain_active), 128);
    for (int i = 0; (i < 300) && (bus.gain_busy == 1'b1); i++) begin
      ph = ph + 3;
      applyStimulus(ph, 1, 0, 0);
    end
    compare("clamp_busy_cleared", int'(bus.gain_busy), 0);
    compare("clamp_crossing_phase", ph, 517);
    compare("clamp_gain", int'(bus.gain_active), 256);

    $display("[TB] retarget before crossing");
    applyStimulus(600, 1, 1, 64);
    applyStimulus(700, 1, 1, 32);
    applyStimulus(800, 1, 0, 0);
    applyStimulus(900, 1, 0, 0);
    compare("retarget_pending", int'(bus.gain_active), 256);
    applyStimulus(10, 1, 0, 0);
    applyStimulus(20, 1, 0, 0);
    applyStimulus(30, 1, 0, 0);
    compare("retarget_gain", int'(bus.gain_active), 32);
    compare("retarget_idle", int'(bus.gain_busy), 0);

    $display("[TB] reset with a gain pending");
    applyStimulus(300, 1, 1, 200);
    applyStimulus(400, 1, 0, 0);
    #200;
    reset = 1'b1;
    #1;
    compare("midreset_valid", int'(bus.sample_valid), 0);
    compare("midreset_sample", sampleNow(), 0);
    compare("midreset_gain", int'(bus.gain_active), 256);
    compare("midreset_busy", int'(bus.gain_busy), 0);
    modelReset();
    bus.phase_valid = 1'b0;
    bus.gain_load   = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(0, 0, 0, 0);
    applyStimulus(256, 1, 0, 0);
    applyStimulus(0, 0, 0, 0);
    compare("post_reset_latency_v0", int'(bus.sample_valid), 0);
    applyStimulus(0, 0, 0, 0);
    compare("post_reset_latency_v1", int'(bus.sample_valid), 1);
    compare("post_reset_sample", sampleNow(), 32767);

    $display("[TB] randomized traffic");
    ph = int'($urandom_range(0, 1023));
    for (int i = 0; i < 800; i++) begin
      v  = ($urandom_range(0, 9) != 0);
      ld = ($urandom_range(0, 24) == 0);
      g  = int'($urandom_range(0, 511));
      if ($urandom_range(0, 49) == 0) ph = int'($urandom_range(0, 1023));
      else if (v) ph = (ph + int'($urandom_range(1, 40))) % 1024;
      applyStimulus(ph, v, ld, g);
    end
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/dds_sine_shaper.md
Name: dds_sine_shaper

Overview:
Stage directly downstream of the 10-bit DDS phase accumulator in the equalizer tone path. Converts each phase word into a signed 16-bit sine sample through a registered quarter-wave ROM, then scales it by a per-band gain. Gain changes take effect only at waveform zero crossings, so band-level updates do not click. Output feeds the band mixer.

Parameters:
OUT_W, 16, output sample width (signed); ROM amplitude 2^(OUT_W-1)-1 = 32767.
GAIN_W, 9, gain width (unsigned); 256 = unity, inputs above 256 clamp to 256.
GAIN_RESET, 256, gain_active value after reset.

Ports:
clock  in  1  system clock (1 MHz)
reset  in  1  reset
phase_in  in  10  phase word from accumulator
phase_valid  in  1  phase_in is valid this cycle (tie high for a free-running accumulator)
gain_in  in  GAIN_W  requested gain
gain_load  in  1  one-cycle pulse: capture gain_in as pending target
sample_out  out  OUT_W  signed scaled sine sample
sample_valid  out  1  sample_out updated this cycle
gain_active  out  GAIN_W  gain currently applied
gain_busy  out  1  pending gain not yet fully applied

Behaviour:
- Reset is asynchronous, active-high, named reset. Clock is named clock.
- Reset values: sample_out=0, sample_valid=0, gain_active=GAIN_RESET, gain_busy=0, pending target=GAIN_RESET, previous-quadrant register=0, all pipeline valids=0.
- ROM: 256 entries, lut[k]=round(32767*sin(2*pi*(k+0.5)/1024)), so lut[0]=101 and lut[255]=32767. Read is registered.
- Quadrant q=phase[9:8], p=phase[7:0]. q0: +lut[p]; q1: +lut[255-p]; q2: -lut[p]; q3: -lut[255-p].
- Pipeline: S1 registers phase and valid; S2 ROM read with sign/mirror applied; S3 multiplies and shifts. Latency is exactly 3 clocks from phase_valid to sample_valid.
- Throughput is 1 sample per clock. Bubbles (phase_valid=0) propagate as sample_valid=0. sample_out holds its last value while sample_valid=0.
- Scaling: product = signed sine (16b) * unsigned gain (9b) into a 25-bit signed result; sample_out = product >>> 8 (arithmetic shift, truncation toward -inf).
  - Gain 256 gives sample_out equal to the ROM value exactly.
  - Gain 0 gives 0.
  - No overflow is possible.
- gain_load: clamp gain_in to 256, store it as the pending target, set gain_busy=1. A new gain_load while busy overwrites the target.
- Zero-crossing event: detected at S1 on a valid phase whose quadrant is 0 and the previous valid quadrant was 3, or whose quadrant is 2 and the previous valid quadrant was 1. The previous-quadrant register updates only on valid phases.
- On a zero-crossing event while busy, gain_active is set to the target and gain_busy clears. The new gain applies starting with the sample from that same phase word.
- If gain_load and a crossing event occur in the same cycle, the crossing applies the old target, and the new target then becomes pending (busy stays 1).
- Reset mid-operation flushes the pipeline (sample_valid=0 next cycle) and discards any pending gain.

Optional Feature:
Macro GAIN_RAMP_EN.
- Defined: the first crossing event after gain_load starts a ramp. gain_active then steps by 1 LSB toward the target on every valid S1 sample, and gain_busy clears when it equals the target. A new gain_load during a ramp retargets it, and the ramp continues from the current gain_active.
- Undefined: gain_active jumps to the target in one step at the crossing, as described under Behaviour.

Test Plan:
- Reset, then phase_in=0, 256, 512, 768 with valid each cycle -> after 3 clocks, samples 101, 32767, -101, -32767; gain_active=256.
- phase_valid pattern 1,0,1 -> sample_valid pattern 1,0,1, delayed exactly 3 clocks; sample_out held during the bubble.
- Gain 128 applied, phase 256 -> sample_out=16383. Phase 768 -> -16384 (truncation toward -inf).
- gain_load gain_in=400 at phase 100 with increment 3 -> gain_busy=1. No change until the first phase with q=2 after q=1; from that sample on, gain_active=256 (clamped) and busy=0.
- gain_load 64 then gain_load 32 before any crossing -> only 32 is applied at the crossing. With GAIN_RAMP_EN, from 256, gain_active decreases by 1 per valid sample after the crossing and reaches 32 after 224 samples.
- Assert reset mid-stream with a gain pending -> sample_valid=0 and sample_out=0 immediately; gain_active=256, gain_busy=0; after release, first sample_valid appears 3 clocks after the first valid phase.
